// File: rtl/shift_add_mul.sv
// Iterative shift-and-add multiplier: low 32 bits of a*b, one partial-product add per cycle.
// Operands in and result out use valid/ready handshakes so the pipeline can stall on it.
module shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplr_q, mplr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [31:0] sum_s;
  logic [31:0] acc_step_s;

  Add u_add (
    .a   (acc_q),
    .b   (mcand_q),
    .sum (sum_s)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

  // Next-state and datapath update; every register holds unless its state says otherwise.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplr_d     = mplr_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    acc_step_s = mplr_q[0] ? sum_s : acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = 32'd0;
          mcand_d = a;
          mplr_d  = b;
          cnt_d   = 5'd0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d   = acc_step_s;
        mcand_d = {mcand_q[30:0], 1'b0};
        mplr_d  = {1'b0, mplr_q[31:1]};
        cnt_d   = cnt_q + 5'd1;
        // Stop as soon as no multiplier bits remain, so latency tracks msb of b.
        if ((mplr_q[31:1] == 31'd0) || (cnt_q == 5'd31)) begin
          state_d  = DONE;
          result_d = acc_step_s;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplr_q   <= 32'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carry; carry-out dropped.
module Add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [30:0] g;
  logic [31:0] p;
  logic [31:0] c;

  assign g    = a[30:0] & b[30:0];
  assign p    = a ^ b;
  assign c[0] = 1'b0;

  for (genvar gi = 0; gi < 8; gi++) begin : g_cla
    localparam int B = gi * 4;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    if (gi < 7) begin : g_cout
      assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B])
                    | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end
  end

  assign sum = p ^ c;

endmodule
